mem_read_arbiter: RTL and testbench
===================================

MEM_READ_ARBITER -- requirements
Module: mem_read_arbiter

Interface
REQ-001 Parameter ADDRESS_SIZE, default 28: memory address width in bits.
REQ-002 Parameter DATA_WIDTH, default 16: memory read data width in bits.
REQ-003 Parameter MEM_LATENCY, default 1, legal range 1..15: cycles from `mem_rd` high to `mem_rdata` valid.
REQ-004 `clk_memory`  in  1  sole clock; all logic on its rising edge.
REQ-005 `reset_n`  in  1  asynchronous, active-low reset.
REQ-006 `p0_req`  in  1  port 0 (core) read request; held high until `p0_ack`.
REQ-007 `p0_addr`  in  ADDRESS_SIZE  port 0 read address; stable while `p0_req` is high.
REQ-008 `p0_ack`  out  1  one-cycle pulse: port 0 request accepted.
REQ-009 `p0_rdata`  out  DATA_WIDTH  port 0 read data.
REQ-010 `p0_rvalid`  out  1  one-cycle pulse: `p0_rdata` valid.
REQ-011 `p1_req`, `p1_addr`, `p1_ack`, `p1_rdata`, `p1_rvalid`: same directions, widths and meanings as REQ-006..010, for port 1 (bridge unloader).
REQ-012 `mem_rd`  out  1  memory read strobe, one cycle per access.
REQ-013 `mem_addr`  out  ADDRESS_SIZE  memory read address.
REQ-014 `mem_rdata`  in  DATA_WIDTH  memory read data.
REQ-015 `busy`  out  1  high whenever state is not IDLE.

Function
REQ-016 FSM states: IDLE, WAIT, RESP. At most one read outstanding.
REQ-017 Requests are sampled only in IDLE. If a requester drops `req` before being granted, the request is withdrawn with no ack.
REQ-018 Grant in cycle T (IDLE, at least one req high):
- cycle T+1: `mem_rd`=1, `mem_addr`=granted address, granted ack=1.
- state goes to WAIT, latency counter cleared.
REQ-019 `mem_rd` and ack are high for exactly one cycle. `mem_addr` holds its value until the next grant.
REQ-020 WAIT counts MEM_LATENCY cycles starting from the `mem_rd` cycle.
- At the end of cycle T+MEM_LATENCY, `mem_rdata` is captured into the granted port's rdata.
- State goes to RESP.
REQ-021 RESP, cycle T+1+MEM_LATENCY: granted port's rvalid=1 for one cycle. State goes to IDLE.
REQ-022 The non-granted port's rdata, ack and rvalid are unchanged or 0 throughout the access.
REQ-023 Minimum spacing between successive grants is MEM_LATENCY+2 cycles.
REQ-024 If `req` is still high in IDLE after an ack, it is a new request. A requester must drop `req` in the cycle after ack.
REQ-025 Simultaneous requests: arbitration per REQ-030/031. The loser keeps `req` high and is served at the next IDLE.
REQ-026 Latency counter is 4 bits and never wraps (MEM_LATENCY ≤ 15).

Reset
REQ-027 On `reset_n` low, immediately and asynchronously:
- state=IDLE, counter=0;
- all outputs 0: `mem_rd`, `mem_addr`, acks, rdata, rvalids, `busy`;
- last-grant register = port 1.
REQ-028 Reset during WAIT or RESP discards the in-flight read. No rvalid is issued after reset release.
REQ-029 First grant is possible in the first clock edge after `reset_n` rises.

Configuration
REQ-030 With macro MEM_ARB_ROUND_ROBIN_EN defined: on simultaneous requests, grant goes to the port not granted last.
- Last-grant updates on every grant.
- Reset value port 1, so port 0 wins the first contention.
REQ-031 Without MEM_ARB_ROUND_ROBIN_EN: fixed priority, port 0 always wins contention. The last-grant register is not implemented.

Verification
REQ-032 MEM_LATENCY=1, `p0_req` with `p0_addr`=0x0000100, `mem_rdata`=0xBEEF at T+1 -> `mem_rd`/`p0_ack` at T+1, `p0_rvalid` with `p0_rdata`=0xBEEF at T+2, `p1_*` stay 0.
REQ-033 MEM_LATENCY=3, `p1_req` addr 0x0000004 -> `mem_addr`=0x0000004 at T+1, `p1_rvalid` at T+4, `busy` high T+1..T+4.
REQ-034 Both req high continuously, fixed priority -> every grant is port 0, `p1_ack` never asserted. With MEM_ARB_ROUND_ROBIN_EN -> grants alternate p0, p1, p0, p1, spaced MEM_LATENCY+2 cycles.
REQ-035 `reset_n` pulsed low during WAIT -> all outputs 0 immediately, no rvalid after release, next request served normally.
REQ-036 `p0_req` high for one cycle only while busy with port 1 -> no `p0_ack`, no `mem_rd` for port 0.

Source files
------------

// File: rtl/mem_read_arbiter.sv
// -----------------------------------------------------------------------------
// mem_read_arbiter
//
// Two-port read arbiter in front of a fixed-latency memory. Port 0 is the
// core and port 1 is the bridge unloader. Only one read is in flight at a
// time. The access sequence is IDLE -> WAIT -> RESP -> IDLE.
//
// Handshake: a requester raises reqN with a stable addrN and keeps it high
// until ackN pulses for one cycle. It must drop reqN in the cycle after ackN,
// because a req still high when the arbiter is back in IDLE counts as a new
// request. Dropping reqN before ackN withdraws the request with no ack.
// Read data arrives as a one-cycle rvalidN pulse, and rdataN then holds until
// the next response on that port.
//
// Configuration:
//   MEM_ARB_ROUND_ROBIN_EN  defined   : contention goes to the port not
//                                       granted last (port 0 wins first).
//                           undefined : fixed priority, port 0 always wins.
//
// Parameters:
//   ADDRESS_SIZE  address width
//   DATA_WIDTH    read data width
//   MEM_LATENCY   1..15, cycles from mem_rd high to mem_rdata valid
//
// Ports:
//   clk_memory               sole clock, rising edge
//   reset_n                  asynchronous active-low reset
//   p0_req/p0_addr           port 0 request and address
//   p0_ack/p0_rdata/p0_rvalid port 0 accept pulse, read data, data-valid pulse
//   p1_*                     same set for port 1
//   mem_rd/mem_addr          memory read strobe (one cycle) and address
//   mem_rdata                memory read data
//   busy                     high whenever the FSM is not IDLE
//   dbg_state                current FSM state (IDLE=0, WAIT=1, RESP=2)
// -----------------------------------------------------------------------------
module mem_read_arbiter #(
    parameter int ADDRESS_SIZE = 28,
    parameter int DATA_WIDTH   = 16,
    parameter int MEM_LATENCY  = 1
) (
    input  logic                    clk_memory,
    input  logic                    reset_n,

    input  logic                    p0_req,
    input  logic [ADDRESS_SIZE-1:0] p0_addr,
    output logic                    p0_ack,
    output logic [DATA_WIDTH-1:0]   p0_rdata,
    output logic                    p0_rvalid,

    input  logic                    p1_req,
    input  logic [ADDRESS_SIZE-1:0] p1_addr,
    output logic                    p1_ack,
    output logic [DATA_WIDTH-1:0]   p1_rdata,
    output logic                    p1_rvalid,

    output logic                    mem_rd,
    output logic [ADDRESS_SIZE-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,

    output logic                    busy,
    output logic [1:0]              dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Value the latency counter holds during the cycle in which mem_rdata is
    // valid. The counter is 0 in the mem_rd cycle.
    localparam logic [3:0] LAT_LAST = 4'(MEM_LATENCY - 1);

    state_t                  state, state_nxt;
    logic [3:0]              lat_cnt, lat_cnt_nxt;
    // Port that owns the current access. Under round robin this register is
    // also the last-grant register. It resets to port 1 so that port 0 wins
    // the first contention.
    logic                    owner, owner_nxt;
    logic                    grant_p1;

    logic                    mem_rd_nxt;
    logic [ADDRESS_SIZE-1:0] mem_addr_nxt;
    logic                    p0_ack_nxt, p1_ack_nxt;
    logic                    p0_rvalid_nxt, p1_rvalid_nxt;
    logic [DATA_WIDTH-1:0]   p0_rdata_nxt, p1_rdata_nxt;

    // Arbitration between the two ports. This value is only used in IDLE
    // when at least one req is high.
`ifdef MEM_ARB_ROUND_ROBIN_EN
    assign grant_p1 = p1_req && (!p0_req || (owner == 1'b0));
`else
    assign grant_p1 = p1_req && !p0_req;
`endif

    always_comb begin
        state_nxt     = state;
        lat_cnt_nxt   = lat_cnt;
        owner_nxt     = owner;
        mem_rd_nxt    = 1'b0;
        mem_addr_nxt  = mem_addr;
        p0_ack_nxt    = 1'b0;
        p1_ack_nxt    = 1'b0;
        p0_rvalid_nxt = 1'b0;
        p1_rvalid_nxt = 1'b0;
        p0_rdata_nxt  = p0_rdata;
        p1_rdata_nxt  = p1_rdata;

        case (state)
            ST_IDLE: begin
                if (p0_req || p1_req) begin
                    state_nxt    = ST_WAIT;
                    lat_cnt_nxt  = 4'd0;
                    owner_nxt    = grant_p1;
                    mem_rd_nxt   = 1'b1;
                    mem_addr_nxt = grant_p1 ? p1_addr : p0_addr;
                    p0_ack_nxt   = !grant_p1;
                    p1_ack_nxt   = grant_p1;
                end
            end
            ST_WAIT: begin
                if (lat_cnt == LAT_LAST) begin
                    // mem_rdata is valid this cycle. Capture it now and
                    // raise rvalid for the RESP cycle.
                    state_nxt = ST_RESP;
                    if (owner) begin
                        p1_rdata_nxt  = mem_rdata;
                        p1_rvalid_nxt = 1'b1;
                    end else begin
                        p0_rdata_nxt  = mem_rdata;
                        p0_rvalid_nxt = 1'b1;
                    end
                end else begin
                    lat_cnt_nxt = lat_cnt + 4'd1;
                end
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_memory or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            lat_cnt   <= 4'd0;
            owner     <= 1'b1;
            mem_rd    <= 1'b0;
            mem_addr  <= '0;
            p0_ack    <= 1'b0;
            p1_ack    <= 1'b0;
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
        end else begin
            state     <= state_nxt;
            lat_cnt   <= lat_cnt_nxt;
            owner     <= owner_nxt;
            mem_rd    <= mem_rd_nxt;
            mem_addr  <= mem_addr_nxt;
            p0_ack    <= p0_ack_nxt;
            p1_ack    <= p1_ack_nxt;
            p0_rvalid <= p0_rvalid_nxt;
            p1_rvalid <= p1_rvalid_nxt;
            p0_rdata  <= p0_rdata_nxt;
            p1_rdata  <= p1_rdata_nxt;
        end
    end

    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_read_arbiter
//
// Random and directed two-port read traffic against mem_read_arbiter, with a
// memory model whose data is valid only in the cycle it is due. A
// transaction-level reference model decides, at each clock edge, whether a
// grant happens, which port wins it, and in which cycles ack, busy and rvalid
// are due. A monitor compares every DUT grant and response against the
// expected queues.
// -----------------------------------------------------------------------------
module tb_mem_read_arbiter;

    localparam int AW  = 28;
    localparam int DW  = 16;
    localparam int LAT = 3;
    localparam int GW  = 16 + 3 + AW;      // {due, ack1, ack0, mem_rd, addr}
    localparam int RW  = 16 + 2 + 2 * DW;  // {due, rv1, rv0, rdata1, rdata0}

    logic          clk_memory = 1'b0;
    logic          reset_n    = 1'b0;
    logic          p0_req     = 1'b0;
    logic [AW-1:0] p0_addr    = '0;
    logic          p0_ack;
    logic [DW-1:0] p0_rdata;
    logic          p0_rvalid;
    logic          p1_req     = 1'b0;
    logic [AW-1:0] p1_addr    = '0;
    logic          p1_ack;
    logic [DW-1:0] p1_rdata;
    logic          p1_rvalid;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata  = '0;
    logic          busy;
    logic [1:0]    dbg_state;

    mem_read_arbiter #(
        .ADDRESS_SIZE (AW),
        .DATA_WIDTH   (DW),
        .MEM_LATENCY  (LAT)
    ) dut (
        .clk_memory (clk_memory),
        .reset_n    (reset_n),
        .p0_req     (p0_req),
        .p0_addr    (p0_addr),
        .p0_ack     (p0_ack),
        .p0_rdata   (p0_rdata),
        .p0_rvalid  (p0_rvalid),
        .p1_req     (p1_req),
        .p1_addr    (p1_addr),
        .p1_ack     (p1_ack),
        .p1_rdata   (p1_rdata),
        .p1_rvalid  (p1_rvalid),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // ---------------------------------------------------------------- clock
    always #5 clk_memory = ~clk_memory;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [GW-1:0] exp_gnt_q[$];
    logic [RW-1:0] exp_rsp_q[$];

    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        return a[DW-1:0] ^ a[AW-1:AW-DW] ^ 16'h5A3C;
    endfunction

    // ---------------------------------------------------------------- memory
    // Data equals mem_fn(address) only in the cycle that is LAT cycles into
    // the access, counting the mem_rd cycle as cycle 1. Every other cycle
    // carries random data.
    int            rd_age = 0;
    logic [AW-1:0] rd_addr = '0;
    initial begin
        forever begin
            @(negedge clk_memory);
            if (!reset_n) rd_age = 0;
            else if (mem_rd) begin
                rd_age  = 1;
                rd_addr = mem_addr;
            end else if (rd_age > 0 && rd_age <= LAT) rd_age++;
            else rd_age = 0;
            mem_rdata = (rd_age == LAT) ? mem_fn(rd_addr) : DW'($urandom);
        end
    end

    // ------------------------------------------------------- reference model
    // Transaction rules: a grant occurs when the arbiter is free and some req
    // is high. The ack and mem_rd cycle follows, and the response comes LAT
    // cycles after that. The arbiter is free again LAT+2 cycles after the
    // grant cycle.
    int            free_at = 0;
    int            busy_lo = -1;
    int            busy_hi = -2;
    logic          last_w  = 1'b1;
    logic          mdl_w;
    logic [AW-1:0] mdl_a;
    logic [DW-1:0] mdl_rdata [2];

    initial begin
        mdl_rdata[0] = '0;
        mdl_rdata[1] = '0;
        forever begin
            @(posedge clk_memory);
            if (!reset_n) begin
                exp_gnt_q.delete();
                exp_rsp_q.delete();
                free_at      = 0;
                busy_lo      = -1;
                busy_hi      = -2;
                last_w       = 1'b1;
                mdl_rdata[0] = '0;
                mdl_rdata[1] = '0;
            end else if (cyc >= free_at && (p0_req || p1_req)) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                mdl_w = (p0_req && p1_req) ? ~last_w : p1_req;
`else
                mdl_w = !p0_req;
`endif
                last_w = mdl_w;
                mdl_a  = mdl_w ? p1_addr : p0_addr;
                exp_gnt_q.push_back({16'(cyc + 1), mdl_w, ~mdl_w, 1'b1, mdl_a});
                mdl_rdata[mdl_w] = mem_fn(mdl_a);
                exp_rsp_q.push_back({16'(cyc + 1 + LAT), mdl_w, ~mdl_w,
                                     mdl_rdata[1], mdl_rdata[0]});
                busy_lo = cyc + 1;
                busy_hi = cyc + 1 + LAT;
                free_at = cyc + LAT + 2;
            end
            cyc = cyc + 1;
        end
    end

    // ----------------------------------------------------------- scoreboard
    logic [GW-1:0] act_g, exp_g;
    logic [RW-1:0] act_r, exp_r;
    logic          exp_busy;
    initial begin
        forever begin
            @(negedge clk_memory);
            if (reset_n) begin
                while (exp_gnt_q.size() > 0 && exp_gnt_q[0][GW-1 -: 16] < 16'(cyc)) begin
                    exp_g = exp_gnt_q.pop_front();
                    total++; bad++;
                    $display("FAIL missing_grant: got none expected %h", exp_g);
                end
                while (exp_rsp_q.size() > 0 && exp_rsp_q[0][RW-1 -: 16] < 16'(cyc)) begin
                    exp_r = exp_rsp_q.pop_front();
                    total++; bad++;
                    $display("FAIL missing_rvalid: got none expected %h", exp_r);
                end
                if (mem_rd || p0_ack || p1_ack) begin
                    act_g = {16'(cyc), p1_ack, p0_ack, mem_rd, mem_addr};
                    total++;
                    if (exp_gnt_q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_grant: got %h expected none", act_g);
                    end else begin
                        exp_g = exp_gnt_q.pop_front();
                        if (act_g !== exp_g) begin
                            bad++;
                            $display("FAIL grant: got %h expected %h", act_g, exp_g);
                        end
                    end
                end
                if (p0_rvalid || p1_rvalid) begin
                    act_r = {16'(cyc), p1_rvalid, p0_rvalid, p1_rdata, p0_rdata};
                    total++;
                    if (exp_rsp_q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_rvalid: got %h expected none", act_r);
                    end else begin
                        exp_r = exp_rsp_q.pop_front();
                        if (act_r !== exp_r) begin
                            bad++;
                            $display("FAIL rvalid: got %h expected %h", act_r, exp_r);
                        end
                    end
                end
                exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
                total++;
                if (busy !== exp_busy) begin
                    bad++;
                    $display("FAIL busy: cycle %0d got %b expected %b", cyc, busy, exp_busy);
                end
            end
        end
    end

    // -------------------------------------------------------------- drivers
    function automatic logic [65:0] all_outputs();
        return {mem_rd, mem_addr, p0_ack, p1_ack, p0_rdata, p1_rdata,
                p0_rvalid, p1_rvalid, busy};
    endfunction

    task automatic check_outputs_zero(input string name);
        total++;
        if (all_outputs() !== '0) begin
            bad++;
            $display("FAIL %s: got %h expected 0", name, all_outputs());
        end
    endtask

    task automatic set_req(input int p, input logic v, input logic [AW-1:0] a);
        if (p == 0) begin p0_req = v; p0_addr = a; end
        else        begin p1_req = v; p1_addr = a; end
    endtask

    task automatic wait_ack(input int p);
        int n;
        n = 0;
        do begin
            @(negedge clk_memory);
            n++;
        end while (!(p == 1 ? p1_ack : p0_ack) && n < 300);
        if (!(p == 1 ? p1_ack : p0_ack)) begin
            total++; bad++;
            $display("FAIL ack_timeout: port %0d got no ack expected ack", p);
        end
    endtask

    // One full request: raise req with address a, hold it until ack, then
    // drop it in the following cycle.
    task automatic do_req(input int p, input logic [AW-1:0] a);
        @(posedge clk_memory); #1;
        set_req(p, 1'b1, a);
        wait_ack(p);
        @(posedge clk_memory); #1;
        set_req(p, 1'b0, a);
    endtask

    task automatic drive_port(input int p, input int n, input int max_gap);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, max_gap)) @(posedge clk_memory);
            do_req(p, AW'($urandom));
        end
    endtask

    // ------------------------------------------------------------ main flow
    initial begin
        int n;
        reset_n = 1'b0;
        repeat (3) @(posedge clk_memory);
        @(negedge clk_memory);
        check_outputs_zero("reset_state");
        @(posedge clk_memory); #1;
        reset_n = 1'b1;

        // Single accesses on each port.
        do_req(0, 28'h0000100);
        repeat (LAT + 3) @(posedge clk_memory);
        do_req(1, 28'h0000004);
        repeat (LAT + 3) @(posedge clk_memory);

        // A one-cycle port 0 pulse while port 1 is being served must be
        // dropped as withdrawn.
        @(posedge clk_memory); #1;
        set_req(1, 1'b1, 28'h0ABCDE0);
        wait_ack(1);
        @(posedge clk_memory); #1;
        set_req(1, 1'b0, 28'h0ABCDE0);
        set_req(0, 1'b1, 28'h0111111);
        @(posedge clk_memory); #1;
        set_req(0, 1'b0, 28'h0111111);
        repeat (LAT + 4) @(posedge clk_memory);

        // Continuous contention, then random traffic on both ports.
        fork
            drive_port(0, 4, 0);
            drive_port(1, 4, 0);
        join
        fork
            drive_port(0, 15, 4);
            drive_port(1, 15, 4);
        join
        repeat (LAT + 4) @(posedge clk_memory);

        // Reset in the middle of WAIT. Outputs must clear at once and the
        // in-flight read must not be answered.
        @(posedge clk_memory); #1;
        set_req(1, 1'b1, 28'h0C0FFEE);
        wait_ack(1);
        #2;
        reset_n = 1'b0;
        set_req(1, 1'b0, 28'h0C0FFEE);
        #1;
        check_outputs_zero("async_reset");
        // A request is already pending when reset releases, so it is
        // granted on the first edge after release.
        set_req(0, 1'b1, 28'h0000200);
        repeat (2) @(posedge clk_memory);
        #1;
        reset_n = 1'b1;
        wait_ack(0);
        @(posedge clk_memory); #1;
        set_req(0, 1'b0, 28'h0000200);
        do_req(1, 28'h0000008);

        n = 0;
        while ((exp_gnt_q.size() > 0 || exp_rsp_q.size() > 0) && n < 100) begin
            @(negedge clk_memory);
            n++;
        end
        total++;
        if (exp_gnt_q.size() > 0 || exp_rsp_q.size() > 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0",
                     exp_gnt_q.size() + exp_rsp_q.size());
        end
        repeat (2) @(posedge clk_memory);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
